// File: rtl/load_store_unit_if.sv
// Data-memory port of the load/store unit.
//   req   : request, held high until ack
//   we    : 1 = write, 0 = read
//   addr  : word-aligned byte address
//   wdata : lane-steered store data
//   be    : byte enables (4'b1111 for reads)
//   ack   : completion; rdata is valid in the same cycle
//   rdata : read word
// master = load/store unit side, slave = memory side.
interface load_store_unit_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, be, input ack, rdata);
  modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/load_store_unit.sv
// Memory stage behind the execute ALU. Runs one load or store at a time
// over a req/ack data-memory port, steers store bytes into lanes, and
// extracts/extends load data. Misaligned, illegal-funct3 and timed-out
// accesses raise a one-cycle exception pulse instead.
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   ex_valid/is_load/is_store/funct3/addr/wdata/rd  op from execute
//   flush               blocks acceptance, suppresses a pending load writeback
//   lsu_busy            access outstanding (upstream stalls)
//   dmem                data-memory port (master side)
//   wb_valid/wb_rd/wb_data   one-cycle load result
//   exc_valid/exc_cause      one-cycle exception (0 ld misalign, 1 st misalign,
//                            2 timeout, 3 illegal funct3)
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16   // 0 disables the timeout
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ex_valid,
  input  logic                    ex_is_load,
  input  logic                    ex_is_store,
  input  logic [2:0]              ex_funct3,
  input  logic [31:0]             ex_addr,
  input  logic [31:0]             ex_wdata,
  input  logic [4:0]              ex_rd,
  input  logic                    flush,
  output logic                    lsu_busy,
  load_store_unit_if.master       dmem,
  output logic                    wb_valid,
  output logic [4:0]              wb_rd,
  output logic [31:0]             wb_data,
  output logic                    exc_valid,
  output logic [1:0]              exc_cause
);

  typedef enum logic {IDLE, ACCESS} state_t;
  typedef enum logic [1:0] {
    CAUSE_LD_MISALIGN = 2'd0,
    CAUSE_ST_MISALIGN = 2'd1,
    CAUSE_TIMEOUT     = 2'd2,
    CAUSE_ILLEGAL     = 2'd3
  } cause_t;

  // Counter only has to reach TIMEOUT_CYCLES-1; the final miss aborts.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [4:0]  rd_q, rd_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        flushed_q, flushed_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        exc_valid_q, exc_valid_d;
  cause_t      exc_cause_q, exc_cause_d;

  // Decode of the op presented by execute.
  logic accept, illegal, misaligned, timeout_hit;
  logic [31:0] load_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign accept  = (state_q == IDLE) && ex_valid && !flush && (ex_is_load ^ ex_is_store);
  assign illegal = ex_is_load ? (ex_funct3 == 3'd3 || ex_funct3 == 3'd6 || ex_funct3 == 3'd7)
                              : (ex_funct3 >= 3'd3);
  // funct3[1:0] encodes size for both loads and stores (0 B, 1 H, 2 W).
  assign misaligned = (ex_funct3[1:0] == 2'd1 && ex_addr[0]) ||
                      (ex_funct3[1:0] == 2'd2 && ex_addr[1:0] != 2'd0);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    ld_byte = dmem.rdata[8*off_q +: 8];
    ld_half = off_q[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
    case (f3_q)
      3'd0:    load_data = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    load_data = {{16{ld_half[15]}}, ld_half};
      3'd4:    load_data = {24'd0, ld_byte};
      3'd5:    load_data = {16'd0, ld_half};
      default: load_data = dmem.rdata;
    endcase
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rd_d        = rd_q;
    f3_d        = f3_q;
    off_d       = off_q;
    cnt_d       = cnt_q;
    flushed_d   = flushed_q;
    wb_valid_d  = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    exc_valid_d = 1'b0;
    exc_cause_d = exc_cause_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (illegal) begin
            exc_valid_d = 1'b1;
            exc_cause_d = CAUSE_ILLEGAL;
          end else if (misaligned) begin
            exc_valid_d = 1'b1;
            exc_cause_d = ex_is_store ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
          end else begin
            state_d   = ACCESS;
            we_d      = ex_is_store;
            addr_d    = {ex_addr[31:2], 2'b00};
            rd_d      = ex_rd;
            f3_d      = ex_funct3;
            off_d     = ex_addr[1:0];
            cnt_d     = '0;
            flushed_d = 1'b0;
            if (ex_is_load) begin
              wdata_d = '0;
              be_d    = 4'b1111;
            end else begin
              case (ex_funct3[1:0])
                2'd0: begin
                  wdata_d = {4{ex_wdata[7:0]}};
                  be_d    = 4'b0001 << ex_addr[1:0];
                end
                2'd1: begin
                  wdata_d = {2{ex_wdata[15:0]}};
                  be_d    = ex_addr[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                  wdata_d = ex_wdata;
                  be_d    = 4'b1111;
                end
              endcase
            end
          end
        end
      end

      ACCESS: begin
        if (flush) flushed_d = 1'b1;
        // An ack on the timeout edge still completes the access normally.
        if (dmem.ack) begin
          state_d = IDLE;
          if (!we_q && !flushed_q && !flush) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
            wb_data_d  = load_data;
          end
        end else if (timeout_hit) begin
          state_d     = IDLE;
          exc_valid_d = 1'b1;
          exc_cause_d = CAUSE_TIMEOUT;
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      rd_q        <= '0;
      f3_q        <= '0;
      off_q       <= '0;
      cnt_q       <= '0;
      flushed_q   <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      exc_valid_q <= 1'b0;
      exc_cause_q <= CAUSE_LD_MISALIGN;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rd_q        <= rd_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      cnt_q       <= cnt_d;
      flushed_q   <= flushed_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      exc_valid_q <= exc_valid_d;
      exc_cause_q <= exc_cause_d;
    end
  end

  // req follows the state flop, so an async reset drops it immediately.
  assign lsu_busy   = (state_q == ACCESS);
  assign dmem.req   = (state_q == ACCESS);
  assign dmem.we    = we_q;
  assign dmem.addr  = addr_q;
  assign dmem.wdata = wdata_q;
  assign dmem.be    = be_q;
  assign wb_valid   = wb_valid_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign exc_valid  = exc_valid_q;
  assign exc_cause  = exc_cause_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit (TIMEOUT_CYCLES = 4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_is_load;
  logic        ex_is_store;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic [4:0]  ex_rd;
  logic        flush;
  logic        lsu_busy;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        exc_valid;
  logic [1:0]  exc_cause;

  int checks = 0;
  int errors = 0;

  load_store_unit_if dmem_bus ();

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ex_valid    (ex_valid),
    .ex_is_load  (ex_is_load),
    .ex_is_store (ex_is_store),
    .ex_funct3   (ex_funct3),
    .ex_addr     (ex_addr),
    .ex_wdata    (ex_wdata),
    .ex_rd       (ex_rd),
    .flush       (flush),
    .lsu_busy    (lsu_busy),
    .dmem        (dmem_bus),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .exc_valid   (exc_valid),
    .exc_cause   (exc_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present an op at the current falling edge; returns at the falling edge
  // after the accept edge with ex_valid dropped.
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
    ex_valid    = 1'b1;
    ex_is_load  = ld;
    ex_is_store = st;
    ex_funct3   = f3;
    ex_addr     = addr;
    ex_wdata    = wd;
    ex_rd       = rd;
    @(posedge clk);
    @(negedge clk);
    ex_valid    = 1'b0;
    ex_is_load  = 1'b0;
    ex_is_store = 1'b0;
  endtask

  // Acknowledge at the next rising edge; returns at the following falling edge.
  task automatic ack_now(input logic [31:0] rdata);
    dmem_bus.ack   = 1'b1;
    dmem_bus.rdata = rdata;
    @(posedge clk);
    @(negedge clk);
    dmem_bus.ack   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({lsu_busy, dmem_bus.req, dmem_bus.we, dmem_bus.be, wb_valid, exc_valid} !== 9'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 0", {lsu_busy, dmem_bus.req, dmem_bus.we,
               dmem_bus.be, wb_valid, exc_valid});
    end
    checks++;
    if ({dmem_bus.addr, dmem_bus.wdata, wb_data, wb_rd, exc_cause} !== 103'd0) begin
      errors++;
      $display("FAIL reset_data: addr %h wdata %h wb_data %h wb_rd %0d cause %0d required 0",
               dmem_bus.addr, dmem_bus.wdata, wb_data, wb_rd, exc_cause);
    end
  endtask

  task automatic test_lw();
    issue(1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 5'd5);
    checks++;
    if ({dmem_bus.req, lsu_busy, dmem_bus.we, dmem_bus.be, dmem_bus.addr} !== {3'b110, 4'hF, 32'h100}) begin
      errors++;
      $display("FAIL lw_request: req %b busy %b we %b be %b addr %h required 1 1 0 1111 00000100",
               dmem_bus.req, lsu_busy, dmem_bus.we, dmem_bus.be, dmem_bus.addr);
    end
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL lw_early_wb: wb_valid %b required 0", wb_valid);
    end
    ack_now(32'hDEADBEEF);
    checks++;
    if ({wb_valid, wb_rd, wb_data, lsu_busy, dmem_bus.req} !== {1'b1, 5'd5, 32'hDEADBEEF, 2'b00}) begin
      errors++;
      $display("FAIL lw_wb: valid %b rd %0d data %h busy %b req %b required 1 5 deadbeef 0 0",
               wb_valid, wb_rd, wb_data, lsu_busy, dmem_bus.req);
    end
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL lw_pulse_width: wb_valid %b required 0", wb_valid);
    end
  endtask

  task automatic test_load_extend();
    logic [2:0]  f3   [5];
    logic [31:0] addr [5];
    logic [31:0] word [5];
    logic [31:0] exp  [5];
    f3[0] = 3'd0; addr[0] = 32'h103; word[0] = 32'h80112233; exp[0] = 32'hFFFFFF80; // LB
    f3[1] = 3'd4; addr[1] = 32'h103; word[1] = 32'h80112233; exp[1] = 32'h00000080; // LBU
    f3[2] = 3'd5; addr[2] = 32'h102; word[2] = 32'h80112233; exp[2] = 32'h00008011; // LHU
    f3[3] = 3'd1; addr[3] = 32'h102; word[3] = 32'h80112233; exp[3] = 32'hFFFF8011; // LH
    f3[4] = 3'd0; addr[4] = 32'h101; word[4] = 32'h80112233; exp[4] = 32'h00000022; // LB
    for (int i = 0; i < 5; i++) begin
      issue(1'b1, 1'b0, f3[i], addr[i], 32'h0, 5'd9);
      ack_now(word[i]);
      checks++;
      if ({wb_valid, wb_data} !== {1'b1, exp[i]}) begin
        errors++;
        $display("FAIL load_extend[%0d]: valid %b data %h required 1 %h", i, wb_valid, wb_data, exp[i]);
      end
    end
  endtask

  task automatic test_store();
    logic [2:0]  f3   [3];
    logic [31:0] addr [3];
    logic [31:0] rs2  [3];
    logic [31:0] ea   [3];
    logic [31:0] ew   [3];
    logic [3:0]  eb   [3];
    f3[0] = 3'd1; addr[0] = 32'h202; rs2[0] = 32'h1234ABCD; ea[0] = 32'h200; ew[0] = 32'hABCDABCD; eb[0] = 4'b1100;
    f3[1] = 3'd0; addr[1] = 32'h101; rs2[1] = 32'h00000055; ea[1] = 32'h100; ew[1] = 32'h55555555; eb[1] = 4'b0010;
    f3[2] = 3'd2; addr[2] = 32'h300; rs2[2] = 32'hCAFEF00D; ea[2] = 32'h300; ew[2] = 32'hCAFEF00D; eb[2] = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, 1'b1, f3[i], addr[i], rs2[i], 5'd3);
      checks++;
      if ({dmem_bus.req, dmem_bus.we, dmem_bus.addr, dmem_bus.wdata, dmem_bus.be} !==
          {2'b11, ea[i], ew[i], eb[i]}) begin
        errors++;
        $display("FAIL store[%0d]: req %b we %b addr %h wdata %h be %b required 1 1 %h %h %b", i,
                 dmem_bus.req, dmem_bus.we, dmem_bus.addr, dmem_bus.wdata, dmem_bus.be, ea[i], ew[i], eb[i]);
      end
      ack_now(32'h0);
      checks++;
      if ({wb_valid, lsu_busy, exc_valid} !== 3'b000) begin
        errors++;
        $display("FAIL store_done[%0d]: wb_valid %b busy %b exc %b required 0 0 0", i,
                 wb_valid, lsu_busy, exc_valid);
      end
    end
  endtask

  task automatic test_exceptions();
    logic        ld   [5];
    logic        st   [5];
    logic [2:0]  f3   [5];
    logic [31:0] addr [5];
    logic        eexc [5];
    logic [1:0]  ecs  [5];
    ld[0] = 1; st[0] = 0; f3[0] = 3'd2; addr[0] = 32'h101; eexc[0] = 1; ecs[0] = 2'd0; // LW misaligned
    ld[1] = 0; st[1] = 1; f3[1] = 3'd3; addr[1] = 32'h100; eexc[1] = 1; ecs[1] = 2'd3; // store f3=3
    ld[2] = 0; st[2] = 1; f3[2] = 3'd1; addr[2] = 32'h201; eexc[2] = 1; ecs[2] = 2'd1; // SH misaligned
    ld[3] = 1; st[3] = 0; f3[3] = 3'd6; addr[3] = 32'h101; eexc[3] = 1; ecs[3] = 2'd3; // illegal beats misalign
    ld[4] = 1; st[4] = 1; f3[4] = 3'd2; addr[4] = 32'h100; eexc[4] = 0; ecs[4] = 2'd0; // both set: ignored
    for (int i = 0; i < 5; i++) begin
      issue(ld[i], st[i], f3[i], addr[i], 32'h0, 5'd1);
      checks++;
      if ({dmem_bus.req, lsu_busy, exc_valid} !== {2'b00, eexc[i]}) begin
        errors++;
        $display("FAIL exc[%0d]: req %b busy %b exc_valid %b required 0 0 %b", i,
                 dmem_bus.req, lsu_busy, exc_valid, eexc[i]);
      end
      if (eexc[i]) begin
        checks++;
        if (exc_cause !== ecs[i]) begin
          errors++;
          $display("FAIL exc_cause[%0d]: got %0d required %0d", i, exc_cause, ecs[i]);
        end
      end
      @(negedge clk);
      checks++;
      if ({exc_valid, dmem_bus.req} !== 2'b00) begin
        errors++;
        $display("FAIL exc_pulse[%0d]: exc_valid %b req %b required 0 0", i, exc_valid, dmem_bus.req);
      end
    end
  endtask

  task automatic test_timeout();
    int n;
    issue(1'b1, 1'b0, 3'd2, 32'h400, 32'h0, 5'd4);
    n = 0;
    for (int i = 0; i < 20 && dmem_bus.req; i++) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL timeout_req_cycles: got %0d required 4", n);
    end
    checks++;
    if ({exc_valid, exc_cause, wb_valid, lsu_busy} !== {1'b1, 2'd2, 2'b00}) begin
      errors++;
      $display("FAIL timeout_exc: exc %b cause %0d wb %b busy %b required 1 2 0 0",
               exc_valid, exc_cause, wb_valid, lsu_busy);
    end
    // Next op accepted after the abort.
    issue(1'b1, 1'b0, 3'd2, 32'h104, 32'h0, 5'd6);
    ack_now(32'h0BADF00D);
    checks++;
    if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd6, 32'h0BADF00D}) begin
      errors++;
      $display("FAIL timeout_recover: valid %b rd %0d data %h required 1 6 0badf00d",
               wb_valid, wb_rd, wb_data);
    end
    // Ack arriving on the timeout edge completes normally.
    issue(1'b1, 1'b0, 3'd2, 32'h108, 32'h0, 5'd8);
    repeat (3) @(negedge clk);
    ack_now(32'h13572468);
    checks++;
    if ({wb_valid, exc_valid, wb_data} !== {2'b10, 32'h13572468}) begin
      errors++;
      $display("FAIL timeout_ack_wins: wb %b exc %b data %h required 1 0 13572468",
               wb_valid, exc_valid, wb_data);
    end
  endtask

  task automatic test_flush();
    int n;
    issue(1'b1, 1'b0, 3'd2, 32'h500, 32'h0, 5'd10);
    n = dmem_bus.req ? 1 : 0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n += dmem_bus.req ? 1 : 0;
    @(negedge clk);
    n += dmem_bus.req ? 1 : 0;
    ack_now(32'h55AA55AA);
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL flush_req_held: got %0d cycles required 3", n);
    end
    checks++;
    if ({wb_valid, exc_valid, lsu_busy, dmem_bus.req} !== 4'b0000) begin
      errors++;
      $display("FAIL flush_no_wb: wb %b exc %b busy %b req %b required 0 0 0 0",
               wb_valid, exc_valid, lsu_busy, dmem_bus.req);
    end
    // Flush on the accept edge blocks the op entirely.
    flush = 1'b1;
    issue(1'b1, 1'b0, 3'd2, 32'h504, 32'h0, 5'd10);
    flush = 1'b0;
    checks++;
    if ({dmem_bus.req, lsu_busy, exc_valid} !== 3'b000) begin
      errors++;
      $display("FAIL flush_blocks_accept: req %b busy %b exc %b required 0 0 0",
               dmem_bus.req, lsu_busy, exc_valid);
    end
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 1'b0, 3'd2, 32'h600, 32'h0, 5'd0);
    ack_now(32'h11112222);
    checks++;
    if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd0, 32'h11112222}) begin
      errors++;
      $display("FAIL rd0_wb: valid %b rd %0d data %h required 1 0 11112222", wb_valid, wb_rd, wb_data);
    end
    issue(1'b1, 1'b0, 3'd4, 32'h601, 32'h0, 5'd7);
    checks++;
    if ({dmem_bus.req, dmem_bus.addr, wb_valid} !== {1'b1, 32'h600, 1'b0}) begin
      errors++;
      $display("FAIL b2b_request: req %b addr %h wb %b required 1 00000600 0",
               dmem_bus.req, dmem_bus.addr, wb_valid);
    end
    ack_now(32'h0000AB00);
    checks++;
    if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd7, 32'h000000AB}) begin
      errors++;
      $display("FAIL b2b_wb: valid %b rd %0d data %h required 1 7 000000ab", wb_valid, wb_rd, wb_data);
    end
  endtask

  task automatic test_reset_mid_access();
    issue(1'b0, 1'b1, 3'd2, 32'h700, 32'hFFFFFFFF, 5'd0);
    checks++;
    if (dmem_bus.req !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_setup: req %b required 1", dmem_bus.req);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({dmem_bus.req, lsu_busy, dmem_bus.we, dmem_bus.be, dmem_bus.addr, dmem_bus.wdata} !== 71'd0) begin
      errors++;
      $display("FAIL rst_mid_access: req %b busy %b we %b be %b addr %h wdata %h required all 0",
               dmem_bus.req, lsu_busy, dmem_bus.we, dmem_bus.be, dmem_bus.addr, dmem_bus.wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n          = 1'b0;
    ex_valid       = 1'b0;
    ex_is_load     = 1'b0;
    ex_is_store    = 1'b0;
    ex_funct3      = 3'd0;
    ex_addr        = 32'h0;
    ex_wdata       = 32'h0;
    ex_rd          = 5'd0;
    flush          = 1'b0;
    dmem_bus.ack   = 1'b0;
    dmem_bus.rdata = 32'h0;
    @(negedge clk);
    test_reset();
    test_lw();
    test_load_extend();
    test_store();
    test_exceptions();
    test_timeout();
    test_flush();
    test_back_to_back();
    test_reset_mid_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
